// File: rtl/rx_message_checker_pkg.sv
// Shared constants for the "Wake Up Aastha" message path: phrase table, terminators,
// result cause codes and checker FSM states.
package rx_message_checker_pkg;

  localparam int unsigned MSG_LEN = 14;
  localparam int unsigned IdxW    = $clog2(MSG_LEN + 1);

  localparam logic [7:0] PHRASE [MSG_LEN] = '{
    8'd87, 8'd97, 8'd107, 8'd101, 8'd32, 8'd85, 8'd112,
    8'd32, 8'd65, 8'd97, 8'd115, 8'd116, 8'd104, 8'd97
  };

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [1:0] {
    StMatch   = 2'd0,
    StContent = 2'd1,
    StLength  = 2'd2,
    StAbort   = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCompare = 2'd1,
    StDrain   = 2'd2
  } state_e;

  function automatic logic is_term(input logic [7:0] b);
    return (b == CR) || (b == LF);
  endfunction

endpackage

// File: rtl/rx_message_checker_if.sv
// Byte-stream input from the UART RX core and result outputs of the message checker.
interface rx_message_checker_if #(
  parameter int unsigned LEN_W = 8
) ();

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_error;
  logic             busy;
  logic             msg_match;
  logic             msg_mismatch;
  logic [1:0]       status;
  logic [LEN_W-1:0] line_len;

  modport master (
    output rx_data, rx_valid, rx_error,
    input  busy, msg_match, msg_mismatch, status, line_len
  );

  modport slave (
    input  rx_data, rx_valid, rx_error,
    output busy, msg_match, msg_mismatch, status, line_len
  );

endinterface

// File: rtl/message_rom.sv
// Combinational phrase table lookup; out-of-range indices read as zero.
module message_rom
  import rx_message_checker_pkg::*;
(
  input  logic [IdxW-1:0] idx_i,
  output logic [7:0]      byte_o
);

  always_comb begin
    byte_o = 8'h00;
    if (32'(idx_i) < MSG_LEN) byte_o = PHRASE[idx_i];
  end

endmodule

// File: rtl/rx_message_checker.sv
// Assembles received bytes into CR/LF-terminated lines and reports whether each line equals
// the fixed phrase, with a cause code and the line length.
module rx_message_checker
  import rx_message_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned LEN_W          = 8
) (
  input logic               uart_clk,
  input logic               rst,
  rx_message_checker_if.slave bus
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(MSG_LEN);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]  cur_len_q, cur_len_d;
  status_e           cause_q, cause_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              busy_q, busy_d;
  logic              match_q, match_d;
  logic              mismatch_q, mismatch_d;
  status_e           status_q, status_d;
  logic [LEN_W-1:0]  line_len_q, line_len_d;

  logic [7:0]       exp_byte;
  logic [LEN_W-1:0] len_inc;
  logic             term;

  message_rom u_rom (
    .idx_i  (idx_q),
    .byte_o (exp_byte)
  );

  assign term    = is_term(bus.rx_data);
  assign len_inc = (cur_len_q == {LEN_W{1'b1}}) ? cur_len_q : cur_len_q + LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cur_len_d  = cur_len_q;
    cause_d    = cause_q;
    status_d   = status_q;
    line_len_d = line_len_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    timer_d    = (bus.rx_valid || state_q == StIdle) ? '0 : timer_q + TimerW'(1);

    if (bus.rx_error) begin
      // The byte arriving with an error is dropped; an error in idle opens an empty line.
      state_d = StDrain;
      cause_d = StAbort;
      idx_d   = '0;
      if (state_q == StIdle) cur_len_d = '0;
    end else if (bus.rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (!term) begin
            cur_len_d = LEN_W'(1);
            if (bus.rx_data == exp_byte) begin
              state_d = StCompare;
              idx_d   = IdxW'(1);
            end else begin
              state_d = StDrain;
              cause_d = StContent;
            end
          end
        end
        StCompare: begin
          if (term) begin
            match_d    = (idx_q == IdxLast);
            mismatch_d = (idx_q != IdxLast);
            status_d   = (idx_q == IdxLast) ? StMatch : StLength;
            line_len_d = cur_len_q;
            state_d    = StIdle;
            idx_d      = '0;
          end else begin
            cur_len_d = len_inc;
            if (idx_q == IdxLast) begin
              state_d = StDrain;
              cause_d = StLength;
              idx_d   = '0;
            end else if (bus.rx_data == exp_byte) begin
              idx_d = idx_q + IdxW'(1);
            end else begin
              state_d = StDrain;
              cause_d = StContent;
              idx_d   = '0;
            end
          end
        end
        StDrain: begin
          if (term) begin
            mismatch_d = 1'b1;
            status_d   = cause_q;
            line_len_d = cur_len_q;
            state_d    = StIdle;
          end else begin
            cur_len_d = len_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && timer_q == TimerLast) begin
      mismatch_d = 1'b1;
      status_d   = StAbort;
      line_len_d = cur_len_q;
      state_d    = StIdle;
      idx_d      = '0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cur_len_q  <= '0;
      cause_q    <= StMatch;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      status_q   <= StMatch;
      line_len_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cur_len_q  <= cur_len_d;
      cause_q    <= cause_d;
      timer_q    <= timer_d;
      busy_q     <= busy_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      status_q   <= status_d;
      line_len_q <= line_len_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.msg_match    = match_q;
  assign bus.msg_mismatch = mismatch_q;
  assign bus.status       = status_q;
  assign bus.line_len     = line_len_q;

endmodule

// File: tb/tb_rx_message_checker.sv
// Directed and randomized line traffic against a line-level reference model of the checker.
module tb_rx_message_checker;

  localparam int unsigned T     = 40;
  localparam int unsigned LEN_W = 8;
  localparam logic [7:0]  CRB   = 8'h0D;
  localparam logic [7:0]  LFB   = 8'h0A;

  logic uart_clk = 1'b0;
  logic rst      = 1'b1;

  rx_message_checker_if #(.LEN_W(LEN_W)) bus ();

  rx_message_checker #(
    .TIMEOUT_CYCLES (T),
    .LEN_W          (LEN_W)
  ) dut (
    .uart_clk (uart_clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 uart_clk = ~uart_clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_match_seen = 0;
  int n_mis_seen   = 0;
  logic both_seen  = 1'b0;
  string phrase = "Wake Up Aastha";

  always @(negedge uart_clk) begin
    if (bus.msg_match) n_match_seen++;
    if (bus.msg_mismatch) n_mis_seen++;
    if (bus.msg_match && bus.msg_mismatch) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge uart_clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge uart_clk);
      #1;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Reference: first differing position within the phrase span is a content error;
  // otherwise any length other than the phrase length is a length error.
  function automatic int ref_status(input byte unsigned q[$]);
    int n = (q.size() < phrase.len()) ? q.size() : phrase.len();
    for (int i = 0; i < n; i++) if (q[i] != phrase[i]) return 1;
    if (q.size() != phrase.len()) return 2;
    return 0;
  endfunction

  task automatic expect_result(input string tag, input int st, input int len);
    check({tag, ".match"}, 32'(bus.msg_match), 32'(st == 0));
    check({tag, ".mismatch"}, 32'(bus.msg_mismatch), 32'(st != 0));
    check({tag, ".status"}, 32'(bus.status), 32'(st));
    check({tag, ".line_len"}, 32'(bus.line_len), 32'((len > 255) ? 255 : len));
    check({tag, ".busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic send_line(input byte unsigned q[$], input logic [7:0] term, input int gapmax,
                           input string tag);
    foreach (q[i]) begin
      send(q[i]);
      if (gapmax > 0) idle($urandom_range(gapmax, 0));
    end
    send(term);
    expect_result(tag, ref_status(q), q.size());
  endtask

  initial begin
    byte unsigned q[$];
    int m0, x0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_error = 1'b0;
    idle(2);
    check("reset.busy", 32'(bus.busy), 0);
    check("reset.match", 32'(bus.msg_match), 0);
    check("reset.mismatch", 32'(bus.msg_mismatch), 0);
    check("reset.status", 32'(bus.status), 0);
    check("reset.line_len", 32'(bus.line_len), 0);
    rst = 1'b0;
    idle(1);

    send_str("Wake Up Aastha");
    check("good.busy_mid", 32'(bus.busy), 1);
    send(CRB);
    expect_result("good_cr", 0, 14);
    idle(1);
    check("good.pulse_len", 32'(bus.msg_match), 0);
    check("good.held_len", 32'(bus.line_len), 14);

    m0 = n_match_seen; x0 = n_mis_seen;
    send_str("Wake Up Aastha");
    send(CRB);
    send(LFB);
    idle(2);
    check("crlf.match_cnt", 32'(n_match_seen - m0), 1);
    check("crlf.mis_cnt", 32'(n_mis_seen - x0), 0);

    send_str("Wake up Aastha"); send(LFB); expect_result("lower_u", 1, 14);
    send_str("Wake Up");        send(CRB); expect_result("short", 2, 7);
    send_str("Wake Up Aasthaa"); send(CRB); expect_result("long", 2, 15);
    for (int i = 0; i < 300; i++) send("x");
    send(CRB);
    expect_result("saturate", 1, 300);

    send_str("Wake");
    idle(T - 1);
    check("to.before_mis", 32'(bus.msg_mismatch), 0);
    check("to.before_busy", 32'(bus.busy), 1);
    idle(1);
    check("to.mismatch", 32'(bus.msg_mismatch), 1);
    check("to.status", 32'(bus.status), 3);
    check("to.line_len", 32'(bus.line_len), 4);
    check("to.busy", 32'(bus.busy), 0);

    send_str("Wake");
    idle(T - 1);
    send("x");
    check("to_edge.mis", 32'(bus.msg_mismatch), 0);
    check("to_edge.busy", 32'(bus.busy), 1);
    send(CRB);
    expect_result("to_edge_end", 1, 5);

    send_str("Wake U");
    bus.rx_error = 1'b1;
    send("p");
    bus.rx_error = 1'b0;
    send_str("p Aastha");
    send(CRB);
    expect_result("rx_err_mid", 3, 14);

    bus.rx_error = 1'b1;
    idle(1);
    bus.rx_error = 1'b0;
    check("rx_err_idle.busy", 32'(bus.busy), 1);
    send_str("abc");
    send(CRB);
    expect_result("rx_err_idle", 3, 3);

    send_str("Wake");
    rst = 1'b1;
    bus.rx_error = 1'b1;
    send(CRB);
    rst = 1'b0;
    bus.rx_error = 1'b0;
    check("rst_mid.busy", 32'(bus.busy), 0);
    check("rst_mid.match", 32'(bus.msg_match), 0);
    check("rst_mid.mismatch", 32'(bus.msg_mismatch), 0);
    check("rst_mid.status", 32'(bus.status), 0);
    check("rst_mid.line_len", 32'(bus.line_len), 0);
    send_str("Wake Up Aastha");
    send(LFB);
    expect_result("after_rst", 0, 14);

    for (int n = 0; n < 30; n++) begin
      int mode = $urandom_range(4, 0);
      q = {};
      if (mode != 4) for (int i = 0; i < phrase.len(); i++) q.push_back(phrase[i]);
      case (mode)
        1: begin
          int p = $urandom_range(phrase.len() - 1, 0);
          q[p] = q[p] + 8'd1;
        end
        2: while (q.size() > $urandom_range(13, 1)) void'(q.pop_back());
        3: repeat ($urandom_range(5, 1)) q.push_back(8'(8'd97 + $urandom_range(25, 0)));
        4: repeat ($urandom_range(20, 1)) q.push_back(8'(8'd65 + $urandom_range(57, 0)));
        default: ;
      endcase
      send_line(q, ($urandom_range(1, 0) == 1) ? CRB : LFB, 3, $sformatf("rand%0d", n));
      if ($urandom_range(2, 0) == 0) begin
        send(LFB);
        check($sformatf("rand%0d.extra_term", n), 32'(bus.msg_match | bus.msg_mismatch), 0);
      end
    end

    check("pulse_exclusive", 32'(both_seen), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
